putbits_packer: RTL and testbench

- MPEG encoder bitstream writer: the write-side counterpart of the decoder's bit-consuming flush buffer.
- Accepts variable-length codes of 0..32 bits and packs them MSB-first into a contiguous bitstream.
- Emits bytes over a valid/ready handshake toward the output byte buffer.
- Supports a byte-align flush that zero-pads the final partial byte, used at start-code and picture boundaries.

---
 rtl/putbits_packer.sv | 124 ++++++++++++
 tb/tb_putbits_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/putbits_packer.sv
// rtl/putbits_packer.sv - MSB-first variable-length code packer with byte output and byte-align flush
module putbits_packer #(
  parameter int ACC_BITS = 64,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_val,
  input  logic [5:0]          in_n,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_byte,
  output logic                flush_done,
  output logic                err,
  output logic [CNT_BITS-1:0] bits_in,
  output logic [CNT_BITS-1:0] bytes_out
);

  localparam int CW = $clog2(ACC_BITS + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  flush_done_q, flush_done_d;
  logic                  err_q, err_d;
  logic [CNT_BITS-1:0]   bits_in_q, bits_in_d;
  logic [CNT_BITS-1:0]   bytes_out_q, bytes_out_d;

  logic                  accept;
  logic                  emit;
  logic [5:0]            n_eff;
  logic [31:0]           code_mask;
  logic [ACC_BITS-1:0]   acc_shift;
  logic [CW-1:0]         cnt_shift;
  logic [CW-1:0]         place_shift;
  logic [ACC_BITS-1:0]   code_wide;

  assign in_ready   = (state_q == RUN) && (cnt_q <= CW'(32));
  assign out_valid  = (state_q == RUN) ? (cnt_q >= CW'(8)) : (cnt_q != '0);
  assign out_byte   = acc_q[ACC_BITS-1 -: 8];
  assign flush_done = flush_done_q;
  assign err        = err_q;
  assign bits_in    = bits_in_q;
  assign bytes_out  = bytes_out_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Over-long codes are clamped to 32 bits; err records the event.
  assign n_eff     = (in_n > 6'd32) ? 6'd32 : in_n;
  assign code_mask = (n_eff == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n_eff) - 32'd1);

  // The outgoing byte is shifted out before the new code is placed, so a
  // same-cycle append lands directly after the surviving bits.
  assign acc_shift = emit ? (acc_q << 8) : acc_q;
  assign cnt_shift = emit ? ((cnt_q >= CW'(8)) ? (cnt_q - CW'(8)) : '0) : cnt_q;

  // Only meaningful on accept, where cnt_shift + n_eff <= 64 <= ACC_BITS.
  assign place_shift = CW'(ACC_BITS) - cnt_shift - CW'(n_eff);
  assign code_wide   = {{(ACC_BITS-32){1'b0}}, (in_val & code_mask)} << place_shift;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_shift;
    cnt_d        = cnt_shift;
    flush_done_d = 1'b0;
    err_d        = err_q;
    bits_in_d    = bits_in_q;
    bytes_out_d  = bytes_out_q;

    if (emit) begin
      bytes_out_d = bytes_out_q + CNT_BITS'(1);
    end

    if (accept) begin
      acc_d     = acc_shift | code_wide;
      cnt_d     = cnt_shift + CW'(n_eff);
      bits_in_d = bits_in_q + CNT_BITS'(n_eff);
      if (in_n > 6'd32) begin
        err_d = 1'b1;
      end
    end

    if (state_q == RUN) begin
      if (flush) begin
        state_d = FLUSH;
      end
    end else begin
      if (cnt_shift == '0) begin
        state_d      = RUN;
        flush_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      bits_in_q    <= '0;
      bytes_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
      bits_in_q    <= bits_in_d;
      bytes_out_q  <= bytes_out_d;
    end
  end

endmodule

// File: tb/tb_putbits_packer.sv
// tb/tb_putbits_packer.sv - directed self-checking bench for putbits_packer
module tb_putbits_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_val;
  logic [5:0]  in_n;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        flush_done;
  logic        err;
  logic [31:0] bits_in;
  logic [31:0] bytes_out;

  int vecs;
  int errs;

  putbits_packer #(.ACC_BITS(64), .CNT_BITS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_val     (in_val),
    .in_n       (in_n),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .flush_done (flush_done),
    .err        (err),
    .bits_in    (bits_in),
    .bytes_out  (bytes_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] v, input logic [5:0] n);
    in_valid = 1'b1;
    in_val   = v;
    in_n     = n;
    step();
    in_valid = 1'b0;
    in_val   = 32'h0;
    in_n     = 6'd0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    write(32'h0000_1FFF, 6'd13);
    if (bits_in !== 32'd13) begin $display("FAIL rst_pre_bits: got %0d want 13", bits_in); errs++; end vecs++;
    if (out_valid !== 1'b1) begin $display("FAIL rst_pre_valid: got %b want 1", out_valid); errs++; end vecs++;
    #2;
    rst = 1'b0;
    #1;
    if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", out_valid); errs++; end vecs++;
    if (in_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", in_ready); errs++; end vecs++;
    if (bits_in !== 32'd0) begin $display("FAIL rst_bits: got %0d want 0", bits_in); errs++; end vecs++;
    if (bytes_out !== 32'd0) begin $display("FAIL rst_bytes: got %0d want 0", bytes_out); errs++; end vecs++;
    if (err !== 1'b0) begin $display("FAIL rst_err: got %b want 0", err); errs++; end vecs++;
    if (out_byte !== 8'h00) begin $display("FAIL rst_byte: got %h want 00", out_byte); errs++; end vecs++;
    rst = 1'b1;
    step();
    if (out_valid !== 1'b0) begin $display("FAIL rst_post_valid: got %b want 0", out_valid); errs++; end vecs++;
  endtask

  task automatic test_basic_pack();
    do_reset();
    out_ready = 1'b1;
    write(32'h0000_0016, 6'd5);
    if (out_valid !== 1'b0) begin $display("FAIL basic_valid5: got %b want 0", out_valid); errs++; end vecs++;
    write(32'h0000_0003, 6'd3);
    if (out_valid !== 1'b1) begin $display("FAIL basic_valid8: got %b want 1", out_valid); errs++; end vecs++;
    if (out_byte !== 8'hB3) begin $display("FAIL basic_byte: got %h want b3", out_byte); errs++; end vecs++;
    if (bits_in !== 32'd8) begin $display("FAIL basic_bits: got %0d want 8", bits_in); errs++; end vecs++;
    step();
    if (bytes_out !== 32'd1) begin $display("FAIL basic_bytes: got %0d want 1", bytes_out); errs++; end vecs++;
    if (out_valid !== 1'b0) begin $display("FAIL basic_drained: got %b want 0", out_valid); errs++; end vecs++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [8];
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    do_reset();
    write(32'hDEAD_BEEF, 6'd32);
    if (in_ready !== 1'b1) begin $display("FAIL bp_ready32: got %b want 1", in_ready); errs++; end vecs++;
    write(32'h0123_4567, 6'd32);
    if (in_ready !== 1'b0) begin $display("FAIL bp_ready64: got %b want 0", in_ready); errs++; end vecs++;
    if (bits_in !== 32'd64) begin $display("FAIL bp_bits: got %0d want 64", bits_in); errs++; end vecs++;
    step();
    if (out_byte !== 8'hDE) begin $display("FAIL bp_hold: got %h want de", out_byte); errs++; end vecs++;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b1) begin $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); errs++; end vecs++;
      if (out_byte !== exp_b[i]) begin $display("FAIL bp_byte[%0d]: got %h want %h", i, out_byte, exp_b[i]); errs++; end vecs++;
      if (in_ready !== (i >= 4)) begin $display("FAIL bp_inready[%0d]: got %b want %b", i, in_ready, (i >= 4)); errs++; end vecs++;
      step();
    end
    if (out_valid !== 1'b0) begin $display("FAIL bp_empty: got %b want 0", out_valid); errs++; end vecs++;
    if (bytes_out !== 32'd8) begin $display("FAIL bp_bytes: got %0d want 8", bytes_out); errs++; end vecs++;
  endtask

  task automatic test_concurrent();
    do_reset();
    write(32'h0000_00A5, 6'd8);
    if (out_byte !== 8'hA5) begin $display("FAIL cc_byte0: got %h want a5", out_byte); errs++; end vecs++;
    out_ready = 1'b1;
    write(32'h0000_000F, 6'd4);
    if (bytes_out !== 32'd1) begin $display("FAIL cc_bytes1: got %0d want 1", bytes_out); errs++; end vecs++;
    if (bits_in !== 32'd12) begin $display("FAIL cc_bits: got %0d want 12", bits_in); errs++; end vecs++;
    if (out_valid !== 1'b0) begin $display("FAIL cc_valid4: got %b want 0", out_valid); errs++; end vecs++;
    write(32'h0000_0000, 6'd4);
    if (out_valid !== 1'b1) begin $display("FAIL cc_valid8: got %b want 1", out_valid); errs++; end vecs++;
    if (out_byte !== 8'hF0) begin $display("FAIL cc_byte1: got %h want f0", out_byte); errs++; end vecs++;
    step();
    if (bytes_out !== 32'd2) begin $display("FAIL cc_bytes2: got %0d want 2", bytes_out); errs++; end vecs++;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    write(32'h0000_0005, 6'd3);
    if (out_valid !== 1'b0) begin $display("FAIL fl_run_partial: got %b want 0", out_valid); errs++; end vecs++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (in_ready !== 1'b0) begin $display("FAIL fl_ready_in: got %b want 0", in_ready); errs++; end vecs++;
    if (out_valid !== 1'b1) begin $display("FAIL fl_valid: got %b want 1", out_valid); errs++; end vecs++;
    if (out_byte !== 8'hA0) begin $display("FAIL fl_byte: got %h want a0", out_byte); errs++; end vecs++;
    if (flush_done !== 1'b0) begin $display("FAIL fl_done_early: got %b want 0", flush_done); errs++; end vecs++;
    step();
    if (flush_done !== 1'b1) begin $display("FAIL fl_done: got %b want 1", flush_done); errs++; end vecs++;
    if (in_ready !== 1'b1) begin $display("FAIL fl_ready_out: got %b want 1", in_ready); errs++; end vecs++;
    if (bytes_out !== 32'd1) begin $display("FAIL fl_bytes: got %0d want 1", bytes_out); errs++; end vecs++;
    in_valid = 1'b1;
    in_val   = 32'h0000_0003;
    in_n     = 6'd2;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    if (flush_done !== 1'b0) begin $display("FAIL fl_done_one: got %b want 0", flush_done); errs++; end vecs++;
    if (out_byte !== 8'hC0) begin $display("FAIL fl_wr_byte: got %h want c0", out_byte); errs++; end vecs++;
    if (bits_in !== 32'd5) begin $display("FAIL fl_wr_bits: got %0d want 5", bits_in); errs++; end vecs++;
    step();
    if (flush_done !== 1'b1) begin $display("FAIL fl_wr_done: got %b want 1", flush_done); errs++; end vecs++;
    if (bytes_out !== 32'd2) begin $display("FAIL fl_wr_bytes: got %0d want 2", bytes_out); errs++; end vecs++;

    do_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (in_ready !== 1'b0) begin $display("FAIL fz_ready: got %b want 0", in_ready); errs++; end vecs++;
    if (out_valid !== 1'b0) begin $display("FAIL fz_valid: got %b want 0", out_valid); errs++; end vecs++;
    if (flush_done !== 1'b0) begin $display("FAIL fz_done_early: got %b want 0", flush_done); errs++; end vecs++;
    step();
    if (flush_done !== 1'b1) begin $display("FAIL fz_done: got %b want 1", flush_done); errs++; end vecs++;
    if (bytes_out !== 32'd0) begin $display("FAIL fz_bytes: got %0d want 0", bytes_out); errs++; end vecs++;
    if (in_ready !== 1'b1) begin $display("FAIL fz_ready_out: got %b want 1", in_ready); errs++; end vecs++;
    step();
    if (flush_done !== 1'b0) begin $display("FAIL fz_done_pulse: got %b want 0", flush_done); errs++; end vecs++;
  endtask

  task automatic test_edge_lengths();
    do_reset();
    write(32'hFFFF_FFFF, 6'd0);
    if (bits_in !== 32'd0) begin $display("FAIL el_zero_bits: got %0d want 0", bits_in); errs++; end vecs++;
    if (out_byte !== 8'h00) begin $display("FAIL el_zero_byte: got %h want 00", out_byte); errs++; end vecs++;
    if (in_ready !== 1'b1) begin $display("FAIL el_zero_ready: got %b want 1", in_ready); errs++; end vecs++;
    write(32'hFFFF_FFFF, 6'd3);
    write(32'h0000_0000, 6'd5);
    if (out_byte !== 8'hE0) begin $display("FAIL el_mask: got %h want e0", out_byte); errs++; end vecs++;
    if (err !== 1'b0) begin $display("FAIL el_err0: got %b want 0", err); errs++; end vecs++;

    do_reset();
    write(32'hFFFF_FFFF, 6'd40);
    if (bits_in !== 32'd32) begin $display("FAIL el_long_bits: got %0d want 32", bits_in); errs++; end vecs++;
    if (err !== 1'b1) begin $display("FAIL el_err1: got %b want 1", err); errs++; end vecs++;
    if (in_ready !== 1'b1) begin $display("FAIL el_long_ready: got %b want 1", in_ready); errs++; end vecs++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_byte !== 8'hFF) begin $display("FAIL el_long_byte[%0d]: got %h want ff", i, out_byte); errs++; end vecs++;
      step();
    end
    if (out_valid !== 1'b0) begin $display("FAIL el_long_empty: got %b want 0", out_valid); errs++; end vecs++;
    if (err !== 1'b1) begin $display("FAIL el_err_sticky: got %b want 1", err); errs++; end vecs++;
    do_reset();
    if (err !== 1'b0) begin $display("FAIL el_err_reset: got %b want 0", err); errs++; end vecs++;
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_val    = 32'h0;
    in_n      = 6'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    rst = 1'b1;
    step();
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_concurrent();
    test_flush();
    test_edge_lengths();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
